// File: rtl/rc4_prga_decrypt.sv
// RC4 PRGA engine: walks the keystream over a pre-scheduled S RAM, XORs it with the
// ciphertext ROM and writes plaintext, optionally aborting on the first implausible byte.
module rc4_prga_decrypt #(
    parameter int unsigned MSG_LEN  = 32,
    parameter int unsigned MSG_AW   = 5,
    parameter bit          CHECK_EN = 1'b1,
    parameter logic [7:0]  CHAR_LO  = 8'h61,
    parameter logic [7:0]  CHAR_HI  = 8'h7A
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              fail,
    output logic [MSG_AW-1:0] bad_idx,
    output logic [7:0]        s_addr,
    output logic [7:0]        s_wdata,
    output logic              s_wren,
    input  logic [7:0]        s_q,
    output logic [MSG_AW-1:0] m_addr,
    input  logic [7:0]        m_q,
    output logic [MSG_AW-1:0] d_addr,
    output logic [7:0]        d_wdata,
    output logic              d_wren
);

    typedef enum logic [3:0] {
        StIdle, StSi, StLi, StSj, StLj, StWi, StWj, StSf, StLf, StWd, StDone
    } state_e;

    localparam logic [MSG_AW-1:0] LastIdx = MSG_AW'(MSG_LEN - 1);

    state_e state_q, state_d;

    logic [7:0]        i_q, i_d, j_q, j_d, si_q, si_d, sj_q, sj_d, f_q, f_d, c_q, c_d;
    logic [MSG_AW-1:0] k_q, k_d, bad_idx_q, bad_idx_d;
    logic              fail_q, fail_d;
    logic [7:0]        plain;
    logic              plain_ok;
    logic              accept;

    assign plain    = f_q ^ c_q;
    assign plain_ok = !CHECK_EN || (plain == 8'h20) || ((plain >= CHAR_LO) && (plain <= CHAR_HI));
    // DONE also accepts so a held start gives back-to-back runs.
    assign accept   = start && ((state_q == StIdle) || (state_q == StDone));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = StSi;
            StSi:    state_d = StLi;
            StLi:    state_d = StSj;
            StSj:    state_d = StLj;
            StLj:    state_d = StWi;
            StWi:    state_d = StWj;
            StWj:    state_d = StSf;
            StSf:    state_d = StLf;
            StLf:    state_d = StWd;
            StWd:    state_d = (!plain_ok || (k_q == LastIdx)) ? StDone : StSi;
            StDone:  state_d = start ? StSi : StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        i_d       = i_q;
        j_d       = j_q;
        k_d       = k_q;
        si_d      = si_q;
        sj_d      = sj_q;
        f_d       = f_q;
        c_d       = c_q;
        fail_d    = fail_q;
        bad_idx_d = bad_idx_q;
        if (accept) begin
            i_d       = 8'd0;
            j_d       = 8'd0;
            k_d       = '0;
            fail_d    = 1'b0;
            bad_idx_d = '0;
        end
        unique case (state_q)
            StSi: i_d = i_q + 8'd1;
            StLi: begin
                si_d = s_q;
                j_d  = j_q + s_q;
            end
            StLj: sj_d = s_q;
            StLf: begin
                f_d = s_q;
                c_d = m_q;
            end
            StWd: begin
                if (!plain_ok) begin
                    fail_d    = 1'b1;
                    bad_idx_d = k_q;
                end else if (k_q != LastIdx) begin
                    k_d = k_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i_q       <= 8'd0;
            j_q       <= 8'd0;
            k_q       <= '0;
            si_q      <= 8'd0;
            sj_q      <= 8'd0;
            f_q       <= 8'd0;
            c_q       <= 8'd0;
            fail_q    <= 1'b0;
            bad_idx_q <= '0;
        end else begin
            i_q       <= i_d;
            j_q       <= j_d;
            k_q       <= k_d;
            si_q      <= si_d;
            sj_q      <= sj_d;
            f_q       <= f_d;
            c_q       <= c_d;
            fail_q    <= fail_d;
            bad_idx_q <= bad_idx_d;
        end
    end

    always_comb begin
        busy    = (state_q != StIdle);
        done    = (state_q == StDone);
        fail    = fail_q;
        bad_idx = bad_idx_q;
        s_addr  = 8'd0;
        s_wdata = 8'd0;
        s_wren  = 1'b0;
        // k is stable for the whole byte, so the ROM output is valid whenever LF samples it.
        m_addr  = ((state_q != StIdle) && (state_q != StDone)) ? k_q : '0;
        d_addr  = '0;
        d_wdata = 8'd0;
        d_wren  = 1'b0;
        unique case (state_q)
            StSi: s_addr = i_q + 8'd1;
            StSj: s_addr = j_q;
            StWi: begin
                s_addr  = i_q;
                s_wdata = sj_q;
                s_wren  = 1'b1;
            end
            StWj: begin
                s_addr  = j_q;
                s_wdata = si_q;
                s_wren  = 1'b1;
            end
            StSf: s_addr = si_q + sj_q;
            StWd: begin
                d_addr  = k_q;
                d_wdata = plain;
                d_wren  = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_rc4_prga_decrypt.sv
// Bench for rc4_prga_decrypt: two instances (unchecked, len 9; checked, len 8) with
// synchronous memory models, a reference RC4 keystream model and a write scoreboard.
module tb_rc4_prga_decrypt;

    localparam int AW = 4;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [7:0]    data;
    } wr_t;

    typedef struct packed {
        int          dut;
        bit          ksa;
        bit          craft;
        logic [71:0] text;
        logic [7:0]  b0;
        logic [7:0]  b1;
        bit          efail;
        int          ebad;
        int          edone;
    } row_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          start[2], rst_n[2], busy[2], done[2], fail[2], s_wren[2], d_wren[2];
    logic [AW-1:0] bad_idx[2], m_addr[2], d_addr[2];
    logic [7:0]    s_addr[2], s_wdata[2], s_q[2], m_q[2], d_wdata[2];

    logic [7:0] s_mem[2][256];
    logic [7:0] ref_s[2][256];
    logic [7:0] m_mem[2][16];
    logic [7:0] d_mem[2][16];
    wr_t        sb_q[2][$];
    wr_t        mon_wr;
    row_t       rows[6];
    int         n_cmp = 0;
    int         n_bad = 0;

    rc4_prga_decrypt #(
        .MSG_LEN(9), .MSG_AW(AW), .CHECK_EN(1'b0), .CHAR_LO(8'h61), .CHAR_HI(8'h7A)
    ) u_dut0 (
        .clk(clk), .rst_n(rst_n[0]), .start(start[0]), .busy(busy[0]), .done(done[0]),
        .fail(fail[0]), .bad_idx(bad_idx[0]), .s_addr(s_addr[0]), .s_wdata(s_wdata[0]),
        .s_wren(s_wren[0]), .s_q(s_q[0]), .m_addr(m_addr[0]), .m_q(m_q[0]),
        .d_addr(d_addr[0]), .d_wdata(d_wdata[0]), .d_wren(d_wren[0])
    );

    rc4_prga_decrypt #(
        .MSG_LEN(8), .MSG_AW(AW), .CHECK_EN(1'b1), .CHAR_LO(8'h61), .CHAR_HI(8'h7A)
    ) u_dut1 (
        .clk(clk), .rst_n(rst_n[1]), .start(start[1]), .busy(busy[1]), .done(done[1]),
        .fail(fail[1]), .bad_idx(bad_idx[1]), .s_addr(s_addr[1]), .s_wdata(s_wdata[1]),
        .s_wren(s_wren[1]), .s_q(s_q[1]), .m_addr(m_addr[1]), .m_q(m_q[1]),
        .d_addr(d_addr[1]), .d_wdata(d_wdata[1]), .d_wren(d_wren[1])
    );

    always @(posedge clk) begin
        for (int g = 0; g < 2; g++) begin
            if (s_wren[g]) s_mem[g][s_addr[g]] <= s_wdata[g];
            s_q[g] <= s_mem[g][s_addr[g]];
            m_q[g] <= m_mem[g][m_addr[g]];
            if (d_wren[g]) d_mem[g][d_addr[g]] <= d_wdata[g];
        end
    end

    // Write monitor: every result write must match the next scoreboard entry.
    always @(negedge clk) begin
        for (int g = 0; g < 2; g++) begin
            if (s_wren[g] || d_wren[g]) begin
                n_cmp++;
                if (s_wren[g] && d_wren[g]) begin
                    n_bad++;
                    $display("FAIL wren_excl dut%0d: both enables high, required at most one", g);
                end
            end
            if (d_wren[g]) begin
                n_cmp++;
                if (sb_q[g].size() == 0) begin
                    n_bad++;
                    $display("FAIL d_write dut%0d: got write addr %0d data %h, required none",
                             g, d_addr[g], d_wdata[g]);
                end else begin
                    mon_wr = sb_q[g].pop_front();
                    if (d_addr[g] !== mon_wr.addr || d_wdata[g] !== mon_wr.data) begin
                        n_bad++;
                        $display("FAIL d_write dut%0d: got addr %0d data %h, required addr %0d data %h",
                                 g, d_addr[g], d_wdata[g], mon_wr.addr, mon_wr.data);
                    end
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    function automatic int msg_len(input int g);
        return (g == 0) ? 9 : 8;
    endfunction

    function automatic logic outs_nonzero(input int g);
        return |{busy[g], done[g], fail[g], bad_idx[g], s_addr[g], s_wdata[g], s_wren[g],
                 m_addr[g], d_addr[g], d_wdata[g], d_wren[g]};
    endfunction

    task automatic load_s(input int g, input bit ksa);
        logic [7:0] key[3];
        logic [7:0] t;
        int j;
        key[0] = 8'h4B;
        key[1] = 8'h65;
        key[2] = 8'h79;
        for (int x = 0; x < 256; x++) ref_s[g][x] = 8'(x);
        if (ksa) begin
            j = 0;
            for (int x = 0; x < 256; x++) begin
                j = (j + int'(ref_s[g][x]) + int'(key[x % 3])) & 255;
                t = ref_s[g][x];
                ref_s[g][x] = ref_s[g][j];
                ref_s[g][j] = t;
            end
        end
        for (int x = 0; x < 256; x++) s_mem[g][x] = ref_s[g][x];
        for (int x = 0; x < 16; x++) d_mem[g][x] = 8'h00;
    endtask

    // mode 0: keep ROM, 1: ROM = text, 2: ROM crafted so plaintext = text.
    task automatic model(input int g, input int mode, input logic [71:0] text,
                         output bit ef, output int ebad, output int edone);
        logic [7:0] s[256];
        logic [7:0] t, ks, p;
        int i, j, len;
        len = msg_len(g);
        for (int x = 0; x < 256; x++) s[x] = ref_s[g][x];
        i = 0;
        j = 0;
        ef = 1'b0;
        ebad = 0;
        edone = 9 * len + 1;
        for (int k = 0; k < len; k++) begin
            wr_t w;
            i = (i + 1) & 255;
            j = (j + int'(s[i])) & 255;
            t = s[i];
            s[i] = s[j];
            s[j] = t;
            ks = s[(int'(s[i]) + int'(s[j])) & 255];
            if (mode == 1) m_mem[g][k] = text[8*(len-1-k) +: 8];
            if (mode == 2) m_mem[g][k] = ks ^ text[8*(len-1-k) +: 8];
            p = ks ^ m_mem[g][k];
            w.addr = AW'(k);
            w.data = p;
            sb_q[g].push_back(w);
            if (g == 1 && !((p >= 8'h61 && p <= 8'h7A) || p == 8'h20)) begin
                ef = 1'b1;
                ebad = k;
                edone = 9 * (k + 1) + 1;
                break;
            end
        end
        for (int x = 0; x < 256; x++) ref_s[g][x] = s[x];
    endtask

    task automatic start_and_wait(input int g, input int poke, output int cyc);
        @(negedge clk);
        start[g] = 1'b1;
        @(negedge clk);
        start[g] = 1'b0;
        cyc = 1;
        chk($sformatf("dut%0d busy_cycle1", g), 32'(busy[g]), 32'd1);
        while (done[g] !== 1'b1 && cyc < 300) begin
            @(negedge clk);
            cyc++;
            start[g] = (cyc == poke);
        end
        start[g] = 1'b0;
    endtask

    task automatic run_row(input int r, input int poke);
        row_t rw;
        bit ef;
        int eb, ed, cyc, g, diffs;
        rw = rows[r];
        g = rw.dut;
        load_s(g, rw.ksa);
        model(g, rw.craft ? 2 : 1, rw.text, ef, eb, ed);
        start_and_wait(g, poke, cyc);
        chk($sformatf("row%0d done_cycle", r), 32'(cyc), 32'(rw.edone));
        chk($sformatf("row%0d fail", r), 32'(fail[g]), 32'(rw.efail));
        if (rw.efail) chk($sformatf("row%0d bad_idx", r), 32'(bad_idx[g]), 32'(rw.ebad));
        @(negedge clk);
        chk($sformatf("row%0d done_pulse", r), 32'(done[g]), 32'd0);
        chk($sformatf("row%0d busy_after", r), 32'(busy[g]), 32'd0);
        chk($sformatf("row%0d sb_drained", r), 32'(sb_q[g].size()), 32'd0);
        chk($sformatf("row%0d byte0", r), 32'(d_mem[g][0]), 32'(rw.b0));
        if (!rw.efail || rw.ebad > 0)
            chk($sformatf("row%0d byte1", r), 32'(d_mem[g][1]), 32'(rw.b1));
        if (g == 0) begin
            diffs = 0;
            for (int x = 0; x < 256; x++) if (s_mem[0][x] !== ref_s[0][x]) diffs++;
            chk($sformatf("row%0d s_final_diffs", r), 32'(diffs), 32'd0);
        end
        if (r == 0) chk("row0 s2_after", 32'(s_mem[0][2]), 32'd3);
        sb_q[g].delete();
    endtask

    initial begin
        bit ef1, ef2, saw_done;
        int eb1, eb2, ed1, ed2, cyc, cyc2;

        rows[0] = '{dut:0, ksa:1'b0, craft:1'b0, text:72'h0, b0:8'h02, b1:8'h05,
                    efail:1'b0, ebad:0, edone:82};
        rows[1] = '{dut:0, ksa:1'b1, craft:1'b0, text:72'hBB_F3_16_E8_D9_40_AF_0A_D3,
                    b0:8'h50, b1:8'h6C, efail:1'b0, ebad:0, edone:82};
        rows[2] = '{dut:1, ksa:1'b0, craft:1'b1, text:72'h00_61_62_20_63_64_78_79_7A,
                    b0:8'h61, b1:8'h62, efail:1'b0, ebad:0, edone:73};
        rows[3] = '{dut:1, ksa:1'b1, craft:1'b1, text:72'h00_61_62_63_41_65_66_67_68,
                    b0:8'h61, b1:8'h62, efail:1'b1, ebad:3, edone:37};
        rows[4] = '{dut:1, ksa:1'b0, craft:1'b1, text:72'h00_7B_62_63_64_65_66_67_68,
                    b0:8'h7B, b1:8'h00, efail:1'b1, ebad:0, edone:10};
        rows[5] = '{dut:1, ksa:1'b0, craft:1'b1, text:72'h00_61_62_63_64_65_66_67_60,
                    b0:8'h61, b1:8'h62, efail:1'b1, ebad:7, edone:73};

        for (int g = 0; g < 2; g++) begin
            start[g] = 1'b0;
            rst_n[g] = 1'b1;
        end
        #2;
        rst_n[0] = 1'b0;
        rst_n[1] = 1'b0;
        repeat (3) @(negedge clk);
        chk("dut0 reset_outs", 32'(outs_nonzero(0)), 32'd0);
        chk("dut1 reset_outs", 32'(outs_nonzero(1)), 32'd0);
        rst_n[0] = 1'b1;
        rst_n[1] = 1'b1;
        @(negedge clk);
        chk("dut1 idle_after_reset", 32'(outs_nonzero(1)), 32'd0);

        for (int r = 0; r < 6; r++) run_row(r, 0);

        // Start pulse in the middle of a run must not disturb it.
        run_row(2, 20);

        // Reset at the first cycle of byte 5.
        load_s(1, 1'b0);
        model(1, 2, 72'h00_61_62_63_64_65_66_67_68, ef1, eb1, ed1);
        @(negedge clk);
        start[1] = 1'b1;
        @(negedge clk);
        start[1] = 1'b0;
        cyc = 1;
        while (cyc < 46) begin
            @(negedge clk);
            cyc++;
        end
        rst_n[1] = 1'b0;
        #1;
        chk("midrst outs_zero", 32'(outs_nonzero(1)), 32'd0);
        chk("midrst pending_writes", 32'(sb_q[1].size()), 32'd3);
        sb_q[1].delete();
        saw_done = 1'b0;
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            if (n == 2) rst_n[1] = 1'b1;
            if (done[1] === 1'b1) saw_done = 1'b1;
        end
        chk("midrst no_done", 32'(saw_done), 32'd0);
        run_row(2, 0);

        // Start held high: second run follows DONE directly with fail cleared.
        load_s(1, 1'b0);
        model(1, 2, 72'h00_61_62_63_41_65_66_67_68, ef1, eb1, ed1);
        model(1, 0, 72'h0, ef2, eb2, ed2);
        @(negedge clk);
        start[1] = 1'b1;
        @(negedge clk);
        cyc = 1;
        while (done[1] !== 1'b1 && cyc < 300) begin
            @(negedge clk);
            cyc++;
        end
        chk("b2b run1 done_cycle", 32'(cyc), 32'd37);
        chk("b2b run1 fail", 32'(fail[1]), 32'd1);
        chk("b2b run1 bad_idx", 32'(bad_idx[1]), 32'd3);
        @(negedge clk);
        start[1] = 1'b0;
        cyc2 = 1;
        chk("b2b run2 busy_cycle1", 32'(busy[1]), 32'd1);
        chk("b2b run2 done_low", 32'(done[1]), 32'd0);
        chk("b2b run2 fail_cleared", 32'(fail[1]), 32'd0);
        chk("b2b run2 bad_idx_cleared", 32'(bad_idx[1]), 32'd0);
        while (done[1] !== 1'b1 && cyc2 < 300) begin
            @(negedge clk);
            cyc2++;
        end
        chk("b2b run2 done_cycle", 32'(cyc2), 32'(ed2));
        chk("b2b run2 fail", 32'(fail[1]), 32'(ef2));
        if (ef2) chk("b2b run2 bad_idx", 32'(bad_idx[1]), 32'(eb2));
        @(negedge clk);
        chk("b2b sb_drained", 32'(sb_q[1].size()), 32'd0);
        chk("b2b idle", 32'(busy[1]), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
